uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// common to the receiver and the transmitter.
package uart_pkg;

    // Default frame geometry shared with the transmitter.
    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable
// reset value so an idle-high line does not look active out of reset.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the rx line, finds the start bit, samples each
// bit at mid-bit (LSB first), checks the stop bit and pulses valid/frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    // Counter values at the sample points: HALF-1 lands on mid start bit,
    // CLKS_PER_BIT-1 lands on mid of every following bit.
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    // Line synchroniser; resets high so reset never looks like a start bit.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: bit timing, sampling and frame checking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be taken as a new start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural transmitter pushes the expected
// pulse (kind, data, cycle) per frame; a monitor checks every pulse it sees.
module tb_uart_rx;

    localparam int unsigned C    = 16;
    localparam int unsigned LAT  = 2 + C / 2 + 9 * C + 1;   // rx fall -> pulse

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;
    bit         idle_busy;

    uart_rx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame starting now (caller is 1 time unit after a clock edge).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        if (stop) last_good = b;
        e.err  = !stop;
        e.data = last_good;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(C);
        end
        rx = stop;
        wait_cyc(C);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            wait_cyc(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: every valid/frame_err pulse must match the head of the queue.
    always @(negedge clk) begin
        if (valid || frame_err) begin
            check("exclusive", {31'b0, valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=0x%0h, expected no pulse (cycle %0d)",
                         valid, frame_err, data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {31'b0, frame_err}, {31'b0, mon_e.err});
                check("pulse_data", {24'b0, data}, {24'b0, mon_e.data});
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int t0;

        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(4);
        check("rst_data", {24'b0, data}, 0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_ferr", {31'b0, frame_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        rst = 1'b1;

        // Idle line for 1000 cycles
        idle_busy = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wait_cyc(1);
            if (busy) idle_busy = 1'b1;
        end
        check("idle_busy", {31'b0, idle_busy}, 0);

        // Single frame
        send_frame(8'hA5, 1'b1);
        wait_drain();
        wait_cyc(10);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain();
        check("b2b_data", {24'b0, data}, 32'hFF);
        wait_cyc(10);

        // False start: 4-cycle low glitch
        t0 = cyc;
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        check("glitch_busy_hi", {31'b0, busy}, 1);
        wait_cyc(t0 + 12 - cyc);
        check("glitch_busy_lo", {31'b0, busy}, 0);
        wait_cyc(20);

        // Framing error, line then held low (break)
        send_frame(8'h3C, 1'b0);
        wait_cyc(40);
        check("break_busy_hi", {31'b0, busy}, 1);
        check("break_data", {24'b0, data}, 32'hFF);
        rx = 1'b1;
        wait_cyc(4);
        check("break_busy_lo", {31'b0, busy}, 0);
        wait_drain();
        wait_cyc(10);

        // Reset in the middle of bit 4 of 0x5A
        rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h5A >> i;
            wait_cyc(C);
        end
        rx = 1'b1;                          // bit 4 of 0x5A
        wait_cyc(C / 2);
        rst = 1'b0;
        wait_cyc(2);
        check("midrst_data", {24'b0, data}, 0);
        check("midrst_valid", {31'b0, valid}, 0);
        check("midrst_ferr", {31'b0, frame_err}, 0);
        check("midrst_busy", {31'b0, busy}, 0);
        wait_cyc(3);
        rst = 1'b1;
        last_good = 8'h00;
        wait_cyc(20);
        send_frame(8'hC3, 1'b1);
        wait_drain();
        check("final_data", {24'b0, data}, 32'hC3);
        check("final_busy", {31'b0, busy}, 0);

        wait_cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish by 2000000");
        $fatal(1);
    end

endmodule
